// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side unpacker.
// FSM state encoding and frame counter width.
package fifo_pkg;

    typedef enum logic {
        EMPTY,
        BUSY
    } unpack_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/fifo_lane_mux.sv
// Selects one OUT_WIDTH lane of a held word.
// Lane 0 is the least significant slice.
module fifo_lane_mux #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int LANE_W    = 2
) (
    input  logic [IN_WIDTH-1:0]  word,
    input  logic [LANE_W-1:0]    lane,
    output logic [OUT_WIDTH-1:0] data
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;

    // One-hot compare per lane keeps the select in range for any RATIO
    always_comb begin
        data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (lane == LANE_W'(i))
                data = word[i*OUT_WIDTH +: OUT_WIDTH];
        end
    end

endmodule

// File: rtl/fifo_unpacker.sv
// Drains FWFT FIFO words into OUT_WIDTH beats
// with frame delimiting on m_last.
module fifo_unpacker
    import fifo_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [IN_WIDTH-1:0]    fifo_data,
    output logic                   r_ready,
    input  logic [15:0]            cfg_words,
    output logic                   m_valid,
    output logic [OUT_WIDTH-1:0]   m_data,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    unpack_state_t          state_q, state_d;
    logic [IN_WIDTH-1:0]    word_q;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [FRAME_CNT_W-1:0] word_idx_q, word_idx_d;
    logic [FRAME_CNT_W-1:0] frame_len_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [OUT_WIDTH-1:0]   lane_data;
    logic                   busy, hs, last_lane, frame_end, pop;

    fifo_lane_mux #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .LANE_W   (LANE_W)
    ) u_mux (
        .word(word_q),
        .lane(lane_q),
        .data(lane_data)
    );

    assign busy      = (state_q == BUSY);
    assign last_lane = (lane_q == LAST_LANE);
    assign frame_end = (word_idx_q == frame_len_q - 1'b1);
    assign hs        = busy & m_ready;

    assign m_valid   = busy;
    assign m_last    = busy & last_lane & frame_end;
    assign m_data    = busy ? lane_data : '0;
    assign frame_cnt = frame_cnt_q;
    assign r_ready   = pop & ~rst;

    // Next state, lane/word index and pop decision
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        word_idx_d = word_idx_q;
        pop        = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    lane_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (hs) begin
                    if (!last_lane) begin
                        lane_d = lane_q + 1'b1;
                    end else begin
                        word_idx_d = m_last ? '0 : word_idx_q + 1'b1;
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            lane_d = '0;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Held word, lane, frame tracking and completed-frame count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q      <= '0;
            lane_q      <= '0;
            word_idx_q  <= '0;
            frame_len_q <= FRAME_CNT_W'(1);
            frame_cnt_q <= '0;
        end else begin
            lane_q     <= lane_d;
            word_idx_q <= word_idx_d;
            if (pop)
                word_q <= fifo_data;
            if (pop && word_idx_d == '0)
                frame_len_q <= (cfg_words == '0) ? FRAME_CNT_W'(1) : cfg_words;
            if (hs && m_last)
                frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed and random bench for fifo_unpacker
// with a FIFO model and beat scoreboard.
module tb_fifo_unpacker;

    typedef struct packed {
        logic [15:0] d;
        logic        last;
        logic [1:0]  lane;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic [63:0] fifo_data;
    logic        r_ready;
    logic [15:0] cfg_words;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_last;
    logic        m_ready;
    logic [15:0] frame_cnt;

    logic [63:0] fq[$];
    beat_t       sb[$];

    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          beats = 0;
    logic [15:0] exp_frames = 0;
    int          m_widx = 0;
    int          m_flen = 1;
    logic        stalled_prev = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    fifo_unpacker #(
        .IN_WIDTH (64),
        .OUT_WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .r_ready   (r_ready),
        .cfg_words (cfg_words),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? 64'h0 : fq[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [63:0] w);
        fq.push_back(w);
        fifo_sync();
    endtask

    task automatic drain(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fq.size() == 0 && sb.size() == 0 && !m_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk("drain_done", done, 1'b1);
    endtask

    // FIFO model: pop on edges where r_ready was high, expand word into beats
    always @(posedge clk) begin
        logic        pop_now;
        logic [63:0] w;
        pop_now = r_ready;
        if (pop_now) begin
            w = fq[0];
            pops++;
            if (m_widx == 0)
                m_flen = (cfg_words == 0) ? 1 : int'(cfg_words);
            for (int l = 0; l < 4; l++)
                sb.push_back('{d: w[l*16 +: 16],
                               last: (l == 3) && (m_widx == m_flen - 1),
                               lane: 2'(l)});
            m_widx = (m_widx == m_flen - 1) ? 0 : m_widx + 1;
            #1;
            void'(fq.pop_front());
            fifo_sync();
        end
    end

    // Scoreboard and protocol checks, sampled mid-cycle
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (fifo_empty)
                chk("no_pop_when_empty", r_ready, 1'b0);
            if (stalled_prev) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid && !m_ready)
                chk("no_pop_stalled", r_ready, 1'b0);
            if (m_valid && r_ready) begin
                chk("pop_on_hs", m_ready, 1'b1);
                if (sb.size() > 0)
                    chk("pop_lane3", sb[0].lane, 2'd3);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 1'b0, 1'b1);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", m_data, e.d);
                    chk("beat_last", m_last, e.last);
                    if (e.last)
                        exp_frames = exp_frames + 1'b1;
                end
                beats++;
            end
            stalled_prev = m_valid && !m_ready;
            prev_data    = m_data;
            prev_last    = m_last;
        end
    end

    initial begin
        logic [15:0] s2 [4];
        int          n;
        int          p0, b0;
        logic [15:0] f0;

        s2[0] = 16'h1111; s2[1] = 16'h2222;
        s2[2] = 16'h3333; s2[3] = 16'h4444;
        m_ready   = 1'b0;
        cfg_words = 16'd1;
        fifo_sync();

        // Reset and idle
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_r_ready", r_ready, 1'b0);
            chk("idle_m_valid", m_valid, 1'b0);
            chk("idle_frame_cnt", frame_cnt, 16'd0);
        end
        tick();

        // Single word
        m_ready = 1'b1;
        p0 = pops;
        push(64'h4444_3333_2222_1111);
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 5) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            chk("s2_valid", m_valid, 1'b1);
            chk("s2_data", m_data, s2[k]);
            chk("s2_last", m_last, k == 3);
            @(negedge clk);
        end
        chk("s2_empty", m_valid, 1'b0);
        chk("s2_frame_cnt", frame_cnt, 16'd1);
        chk("s2_pops", pops - p0, 1);
        tick();

        // Back-to-back frame of three words
        cfg_words = 16'd3;
        m_ready   = 1'b0;
        b0        = beats;
        push({4{16'd0}});
        push({4{16'd1}});
        push({4{16'd2}});
        tick();
        tick();
        chk("s3_held", r_ready, 1'b0);
        m_ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            @(negedge clk);
            chk("s3_valid", m_valid, 1'b1);
            chk("s3_data", m_data, 16'(b / 4));
            chk("s3_last", m_last, b == 11);
            chk("s3_pop", r_ready, (b % 4 == 3) && (b < 8));
        end
        @(negedge clk);
        chk("s3_empty", m_valid, 1'b0);
        chk("s3_beats", beats - b0, 12);
        chk("s3_frame_cnt", frame_cnt, 16'd2);
        tick();

        // Backpressure 1,0,0,1 on the same three-word frame
        b0 = beats;
        push({4{16'd0}});
        push({4{16'd1}});
        push({4{16'd2}});
        for (int c = 0; c < 48; c++) begin
            m_ready = (c % 4 == 0) || (c % 4 == 3);
            tick();
        end
        m_ready = 1'b1;
        drain(20);
        chk("s4_beats", beats - b0, 12);
        chk("s4_frame_cnt", frame_cnt, 16'd3);

        // cfg_words = 0 ends every word as a frame
        cfg_words = 16'd0;
        f0 = frame_cnt;
        push(64'h0D0C_0B0A_0908_0706);
        push(64'h1716_1514_1312_1110);
        drain(30);
        chk("s5_zero_frames", frame_cnt - f0, 16'd2);

        // cfg change mid-frame keeps the running length
        cfg_words = 16'd3;
        f0 = frame_cnt;
        push(64'hA1);
        push(64'hA2);
        push(64'hA3);
        tick();
        tick();
        cfg_words = 16'd2;
        drain(30);
        chk("s5_mid_change", frame_cnt - f0, 16'd1);
        push(64'hB1);
        push(64'hB2);
        drain(30);
        chk("s5_new_len", frame_cnt - f0, 16'd2);
        chk("s5_model", frame_cnt, exp_frames);

        // Reset after beat 2 of a word
        cfg_words = 16'd1;
        b0 = beats;
        push(64'hAAAA_BBBB_CCCC_DDDD);
        push(64'h0123_4567_89AB_CDEF);
        n = 0;
        while (beats < b0 + 2 && n < 20) begin
            tick();
            n++;
        end
        chk("s6_reached_beat2", beats - b0, 2);
        rst = 1'b1;
        sb.delete();
        m_widx     = 0;
        exp_frames = 16'd0;
        #1;
        chk("s6_valid_drop", m_valid, 1'b0);
        chk("s6_no_pop", r_ready, 1'b0);
        chk("s6_fifo_kept", fq.size(), 1);
        tick();
        tick();
        rst = 1'b0;
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("s6_fresh_lane0", m_data, 16'hCDEF);
        chk("s6_frame_cnt_rst", frame_cnt, 16'd0);
        tick();
        drain(20);

        // Random push / backpressure traffic
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 8)
                push({$urandom, $urandom});
            m_ready   = ($urandom_range(0, 3) != 0);
            cfg_words = 16'($urandom_range(0, 4));
            tick();
        end
        m_ready = 1'b1;
        drain(200);
        chk("rand_frame_cnt", frame_cnt, exp_frames);
        chk("rand_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
